// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the fetch stage's pipeline-control inputs, the instruction-memory
// port and the IF/ID pipeline register outputs.
//   master : the fetch unit (drives pc and the IF/ID outputs)
//   slave  : the surrounding pipeline and instruction memory
// Signals:
//   stall, flush              hold / squash requests from downstream
//   branch_taken, branch_offset  taken-branch redirect (signed word offset)
//   jump, jump_target         jump redirect (26-bit word-address field)
//   pc, instruction           instruction-memory address and same-cycle data
//   ifid_instr, ifid_pc_plus1, ifid_valid   IF/ID pipeline register
//   fetch_count               number of valid instructions latched
interface fetch_unit_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, branch_taken, branch_offset, jump, jump_target,
               instruction,
        output pc, ifid_instr, ifid_pc_plus1, ifid_valid, fetch_count
    );

    modport slave (
        output stall, flush, branch_taken, branch_offset, jump, jump_target,
               instruction,
        input  pc, ifid_instr, ifid_pc_plus1, ifid_valid, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: keeps a word-addressed PC, reads instruction
// memory combinationally, and fills the IF/ID register. Handles jump and
// taken-branch redirects (which squash the wrong-path slot), stall, flush,
// bubbles for unprogrammed words, and counts valid fetches.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master (see interface header)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_WORD   = 32'hFFFF_FFFF
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_unit_if.master   bus
);

    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);
    localparam logic [31:0] LAST  = DEPTH - 32'd1;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] ifid_instr_reg;
    logic [31:0] ifid_pc_plus1_reg;
    logic        ifid_valid_reg;
    logic [31:0] fetch_count_reg;

    logic [31:0] pc_next;
    logic        active;      // past the boot cycle
    logic        redirect;
    logic        do_load;     // PC and IF/ID take new values this edge
    logic        do_squash;   // clear ifid_valid without loading (flush while stalled)
    logic        new_valid;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN,
            HOLD: begin
                if (bus.jump || bus.branch_taken) begin
                    state_next = RUN;
                end else if (bus.stall) begin
                    state_next = HOLD;
                end else begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        active    = (state_reg == RUN) || (state_reg == HOLD);
        redirect  = active && (bus.jump || bus.branch_taken);
        // A redirect overrides stall; otherwise stall freezes PC and IF/ID.
        do_load   = active && (redirect || !bus.stall);
        do_squash = active && bus.flush;
        // Redirected slot is wrong-path; NOP_WORD slots are bubbles.
        new_valid = !redirect && !bus.flush && (bus.instruction != NOP_WORD);
    end

    // ---------------- next PC: jump > branch > sequential ----------------
    always_comb begin
        pc_next = (pc_reg == LAST) ? 32'd0 : pc_reg + 32'd1;
        if (bus.jump) begin
            pc_next = {ifid_pc_plus1_reg[31:26], bus.jump_target} % DEPTH;
        end else if (bus.branch_taken) begin
            pc_next = (ifid_pc_plus1_reg + {{16{bus.branch_offset[15]}}, bus.branch_offset}) % DEPTH;
        end
    end

    // ---------------- PC and IF/ID datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg            <= RESET_PC;
            ifid_instr_reg    <= 32'd0;
            ifid_pc_plus1_reg <= 32'd0;
            ifid_valid_reg    <= 1'b0;
            fetch_count_reg   <= 32'd0;
        end else if (do_load) begin
            pc_reg            <= pc_next;
            ifid_instr_reg    <= bus.instruction;
            ifid_pc_plus1_reg <= pc_reg + 32'd1;
            ifid_valid_reg    <= new_valid;
            if (new_valid && (fetch_count_reg != 32'hFFFF_FFFF)) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
        end else if (do_squash) begin
            ifid_valid_reg    <= 1'b0;
        end
    end

    assign bus.pc            = pc_reg;
    assign bus.ifid_instr    = ifid_instr_reg;
    assign bus.ifid_pc_plus1 = ifid_pc_plus1_reg;
    assign bus.ifid_valid    = ifid_valid_reg;
    assign bus.fetch_count   = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] imem [0:1023];

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'd0),
        .IMEM_DEPTH (1024),
        .NOP_WORD   (32'hFFFF_FFFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory model: combinational read at pc.
    assign bus.instruction = imem[bus.pc[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock edge, then sample on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic slot(input string tag, input logic [31:0] e_pc,
                        input logic e_valid, input logic [31:0] e_cnt);
        $display("[%0t] %s pc=%0d instr=%08h pc_plus1=%0d valid=%0b count=%0d",
                 $time, tag, bus.pc, bus.ifid_instr, bus.ifid_pc_plus1,
                 bus.ifid_valid, bus.fetch_count);
        chk({tag, "_pc"},    bus.pc,          e_pc);
        chk({tag, "_valid"}, 32'(bus.ifid_valid), 32'(e_valid));
        chk({tag, "_count"}, bus.fetch_count, e_cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0100_0000 | 32'(i);
        imem[0] = 32'h8C01_03FE;
        imem[1] = 32'hAC01_03FF;
        imem[2] = 32'h0800_0000;
        imem[7] = 32'hFFFF_FFFF;

        rst_n             = 1'b0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 16'd0;
        bus.jump          = 1'b0;
        bus.jump_target   = 26'd0;

        repeat (2) @(negedge clk);
        slot("reset", 32'd0, 1'b0, 32'd0);
        chk("reset_instr", bus.ifid_instr, 32'd0);
        chk("reset_pcp1",  bus.ifid_pc_plus1, 32'd0);

        // Release reset with a jump pending: the boot cycle must ignore it.
        rst_n = 1'b1;
        bus.jump = 1'b1;
        bus.jump_target = 26'd5;
        cyc();
        slot("boot", 32'd0, 1'b0, 32'd0);
        bus.jump = 1'b0;

        cyc();
        slot("fetch0", 32'd1, 1'b1, 32'd1);
        chk("fetch0_instr", bus.ifid_instr, 32'h8C01_03FE);
        chk("fetch0_pcp1",  bus.ifid_pc_plus1, 32'd1);
        cyc();
        slot("fetch1", 32'd2, 1'b1, 32'd2);
        chk("fetch1_instr", bus.ifid_instr, 32'hAC01_03FF);
        chk("fetch1_pcp1",  bus.ifid_pc_plus1, 32'd2);
        cyc();
        slot("fetch2", 32'd3, 1'b1, 32'd3);
        chk("fetch2_instr", bus.ifid_instr, 32'h0800_0000);
        chk("fetch2_pcp1",  bus.ifid_pc_plus1, 32'd3);

        // Jump to 0 while ifid_pc_plus1 = 3.
        bus.jump = 1'b1;
        bus.jump_target = 26'd0;
        cyc();
        slot("jump", 32'd0, 1'b0, 32'd3);
        bus.jump = 1'b0;
        cyc();
        slot("after_jump", 32'd1, 1'b1, 32'd4);
        chk("after_jump_instr", bus.ifid_instr, 32'h8C01_03FE);

        // Walk until ifid_pc_plus1 = 5.
        for (int i = 2; i <= 5; i++) cyc();
        slot("seq5", 32'd5, 1'b1, 32'd8);
        chk("seq5_pcp1", bus.ifid_pc_plus1, 32'd5);

        // Backward branch by -2 from ifid_pc_plus1 = 5.
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'hFFFE;
        cyc();
        slot("branch_back", 32'd3, 1'b0, 32'd8);
        bus.branch_taken = 1'b0;
        cyc();
        slot("fetch3", 32'd4, 1'b1, 32'd9);
        chk("fetch3_instr", bus.ifid_instr, 32'h0100_0003);

        // Three-cycle stall at pc = 4.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            slot("stall", 32'd4, 1'b1, 32'd9);
            chk("stall_instr", bus.ifid_instr, 32'h0100_0003);
        end

        // Stall + branch: redirect wins, ifid_pc_plus1 = 4, offset 3 -> 7.
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'd3;
        cyc();
        slot("stall_branch", 32'd7, 1'b0, 32'd9);
        bus.branch_taken = 1'b0;
        bus.stall = 1'b0;

        // Address 7 holds the NOP pattern: bubble, PC still advances.
        cyc();
        slot("nop7", 32'd8, 1'b0, 32'd9);
        chk("nop7_instr", bus.ifid_instr, 32'hFFFF_FFFF);
        cyc();
        slot("fetch8", 32'd9, 1'b1, 32'd10);

        // Flush alone, then flush with stall.
        bus.flush = 1'b1;
        cyc();
        slot("flush", 32'd10, 1'b0, 32'd10);
        chk("flush_instr", bus.ifid_instr, 32'h0100_0009);
        bus.stall = 1'b1;
        cyc();
        slot("flush_stall", 32'd10, 1'b0, 32'd10);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Reach ifid_pc_plus1 = 1023 and branch +1 -> wraps to 0.
        bus.jump = 1'b1;
        bus.jump_target = 26'd1022;
        cyc();
        slot("jump1022", 32'd1022, 1'b0, 32'd10);
        bus.jump = 1'b0;
        cyc();
        slot("fetch1022", 32'd1023, 1'b1, 32'd11);
        chk("fetch1022_pcp1", bus.ifid_pc_plus1, 32'd1023);
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'd1;
        cyc();
        slot("branch_wrap", 32'd0, 1'b0, 32'd11);
        bus.branch_taken = 1'b0;

        // Sequential wrap from 1023.
        bus.jump = 1'b1;
        bus.jump_target = 26'd1023;
        cyc();
        slot("jump1023", 32'd1023, 1'b0, 32'd11);
        bus.jump = 1'b0;
        cyc();
        slot("seq_wrap", 32'd0, 1'b1, 32'd12);

        // Enter HOLD, then assert reset between edges.
        bus.stall = 1'b1;
        cyc();
        slot("hold", 32'd0, 1'b1, 32'd12);
        #2 rst_n = 1'b0;
        #1;
        slot("async_reset", 32'd0, 1'b0, 32'd0);
        chk("async_reset_instr", bus.ifid_instr, 32'd0);
        chk("async_reset_pcp1",  bus.ifid_pc_plus1, 32'd0);

        // Restart: boot cycle, then first fetch from RESET_PC.
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        cyc();
        slot("reboot", 32'd0, 1'b0, 32'd0);
        cyc();
        slot("refetch0", 32'd1, 1'b1, 32'd1);
        chk("refetch0_instr", bus.ifid_instr, 32'h8C01_03FE);
        chk("refetch0_pcp1",  bus.ifid_pc_plus1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
